// File: rtl/rs232_cmd_parser.sv
// Line-oriented hex command parser between the RS-232 RX/TX FIFOs and a register bus.
// Accepts W<addr><data>CR and R<addr>CR, replying with K, E or the read data in hex.
module rs232_cmd_parser #(
    parameter int P_ADDR_W = 8,
    parameter int P_DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_fifo_empty,
    output logic                rx_fifo_rd_en,
    input  logic [7:0]          rx_fifo_dout,
    output logic [P_ADDR_W-1:0] reg_addr,
    output logic                reg_wr_en,
    output logic [P_DATA_W-1:0] reg_wr_data,
    output logic                reg_rd_en,
    input  logic [P_DATA_W-1:0] reg_rd_data,
    output logic [7:0]          tx_fifo_data,
    output logic                tx_fifo_wr_en,
    input  logic                tx_fifo_full
);
    localparam int NA = P_ADDR_W / 4;
    localparam int ND = P_DATA_W / 4;
    localparam int SW = P_ADDR_W + P_DATA_W;
    localparam int NMAX = NA + ND + 1;
    localparam int CW = $clog2(NMAX + 1);
    localparam int RB = ND + 2;
    localparam int IW = $clog2(RB);
    localparam logic [CW-1:0] CNT_WR = CW'(NA + ND);
    localparam logic [CW-1:0] CNT_RD = CW'(NA);
    localparam logic [CW-1:0] CNT_MAX = CW'(NMAX);
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    typedef enum logic [2:0] {
        S_FETCH, S_WAIT, S_PARSE, S_EXEC, S_RDW, S_RDC, S_RESP
    } state_t;
    typedef enum logic [1:0] {OP_NONE, OP_WR, OP_RD} op_t;

    state_t        state;
    op_t           op;
    logic          err;
    logic          run;
    logic [CW-1:0] cnt;
    logic [SW-1:0] sr;
    logic [7:0]    ch;
    logic [7:0]    rbuf [RB];
    logic [IW-1:0] ridx;
    logic [IW-1:0] rlast;

    function automatic logic is_hex(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) ||
               (c >= 8'h41 && c <= 8'h46) ||
               (c >= 8'h61 && c <= 8'h66);
    endfunction

    // Letters A-F/a-f carry value-9 in their low nibble.
    function automatic logic [3:0] nib(input logic [7:0] c);
        return (c <= 8'h39) ? c[3:0] : c[3:0] + 4'd9;
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    assign rx_fifo_rd_en = run && (state == S_FETCH) && !rx_fifo_empty;
    assign tx_fifo_wr_en = (state == S_RESP) && !tx_fifo_full;
    assign tx_fifo_data  = (state == S_RESP) ? rbuf[ridx] : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            op          <= OP_NONE;
            err         <= 1'b0;
            run         <= 1'b0;
            cnt         <= '0;
            sr          <= '0;
            ch          <= '0;
            ridx        <= '0;
            rlast       <= '0;
            reg_addr    <= '0;
            reg_wr_en   <= 1'b0;
            reg_wr_data <= '0;
            reg_rd_en   <= 1'b0;
            for (int i = 0; i < RB; i++) rbuf[i] <= '0;
        end else begin
            run       <= 1'b1;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            unique case (state)
                S_FETCH: begin
                    if (rx_fifo_rd_en) state <= S_WAIT;
                end
                S_WAIT: begin
                    ch    <= rx_fifo_dout;
                    state <= S_PARSE;
                end
                S_PARSE: begin
                    state <= S_FETCH;
                    if (op == OP_NONE && !err) begin
                        if (ch == 8'h57 || ch == 8'h77) op <= OP_WR;
                        else if (ch == 8'h52 || ch == 8'h72) op <= OP_RD;
                        else if (ch != CR && ch != LF) err <= 1'b1;
                    end else if (is_hex(ch)) begin
                        sr <= {sr[SW-5:0], nib(ch)};
                        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                    end else if (ch == CR) begin
                        state <= S_EXEC;
                    end else begin
                        err <= 1'b1;
                    end
                end
                S_EXEC: begin
                    state <= S_RESP;
                    ridx  <= '0;
                    rlast <= IW'(2);
                    if (err || (op == OP_WR && cnt != CNT_WR) ||
                        (op == OP_RD && cnt != CNT_RD)) begin
                        rbuf[0] <= 8'h45;
                        rbuf[1] <= CR;
                        rbuf[2] <= LF;
                    end else if (op == OP_WR) begin
                        reg_addr    <= sr[SW-1:P_DATA_W];
                        reg_wr_data <= sr[P_DATA_W-1:0];
                        reg_wr_en   <= 1'b1;
                        rbuf[0]     <= 8'h4B;
                        rbuf[1]     <= CR;
                        rbuf[2]     <= LF;
                    end else begin
                        reg_addr  <= sr[P_ADDR_W-1:0];
                        reg_rd_en <= 1'b1;
                        state     <= S_RDW;
                    end
                end
                S_RDW: state <= S_RDC;
                // Read data is valid the cycle after the strobe.
                S_RDC: begin
                    for (int i = 0; i < ND; i++)
                        rbuf[i] <= hex_char(reg_rd_data[P_DATA_W-1-4*i -: 4]);
                    rbuf[ND]   <= CR;
                    rbuf[ND+1] <= LF;
                    rlast      <= IW'(ND + 1);
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (!tx_fifo_full) begin
                        if (ridx == rlast) begin
                            op    <= OP_NONE;
                            err   <= 1'b0;
                            cnt   <= '0;
                            sr    <= '0;
                            ridx  <= '0;
                            state <= S_FETCH;
                        end else begin
                            ridx <= ridx + 1'b1;
                        end
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_rs232_cmd_parser.sv
// Bench for rs232_cmd_parser: directed lines plus random lines checked
// against a line-level model of the command grammar.
module tb_rs232_cmd_parser;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_fifo_empty;
    logic        rx_fifo_rd_en;
    logic [7:0]  rx_fifo_dout = 8'h00;
    logic [7:0]  reg_addr;
    logic        reg_wr_en;
    logic [15:0] reg_wr_data;
    logic        reg_rd_en;
    logic [15:0] reg_rd_data = 16'h0000;
    logic [7:0]  tx_fifo_data;
    logic        tx_fifo_wr_en;
    logic        tx_fifo_full = 1'b0;

    rs232_cmd_parser #(.P_ADDR_W(8), .P_DATA_W(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_fifo_empty(rx_fifo_empty),
        .rx_fifo_rd_en(rx_fifo_rd_en),
        .rx_fifo_dout(rx_fifo_dout),
        .reg_addr(reg_addr),
        .reg_wr_en(reg_wr_en),
        .reg_wr_data(reg_wr_data),
        .reg_rd_en(reg_rd_en),
        .reg_rd_data(reg_rd_data),
        .tx_fifo_data(tx_fifo_data),
        .tx_fifo_wr_en(tx_fifo_wr_en),
        .tx_fifo_full(tx_fifo_full)
    );

    always #5 clk = ~clk;

    // RX FIFO: byte store plus pointers; data appears the cycle after rd_en.
    logic [7:0] rx_mem [8192];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign rx_fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (rx_fifo_rd_en) begin
            rx_fifo_dout <= rx_mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    logic [15:0] rdmem [256];
    always @(posedge clk) begin
        if (reg_rd_en) reg_rd_data <= rdmem[reg_addr];
    end

    typedef struct packed {
        logic        wr;
        logic [7:0]  a;
        logic [15:0] d;
    } bus_t;

    bus_t       exp_bus[$];
    logic [7:0] exp_tx[$];
    logic [7:0] cur[$];
    int n_chk = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    logic [7:0]   last_addr = 8'h00;
    logic [15:0]  last_wdata = 16'h0000;
    logic [127:0] logv = '0;
    int logn = 0;
    bit full_rand = 1'b0;

    task automatic chk(input bit ok, input string name,
                       input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every bus strobe and TX write is matched to the model.
    always @(negedge clk) begin : cmp
        bus_t g;
        bus_t e;
        logic [7:0] eb;
        if (rst_n) begin
            chk(!(rx_fifo_rd_en && rx_fifo_empty), "rd_while_empty",
                128'(rx_fifo_rd_en), 128'(0));
            chk(!(tx_fifo_wr_en && tx_fifo_full), "wr_while_full",
                128'(tx_fifo_wr_en), 128'(0));
            if (reg_wr_en || reg_rd_en) begin
                g = {reg_wr_en, reg_addr, reg_wr_en ? reg_wr_data : 16'h0000};
                last_addr = reg_addr;
                if (reg_wr_en) begin
                    wr_cnt++;
                    last_wdata = reg_wr_data;
                end
                if (reg_rd_en) rd_cnt++;
                if (exp_bus.size() == 0) begin
                    chk(1'b0, "unexpected_bus", 128'(g), 128'(0));
                end else begin
                    e = exp_bus.pop_front();
                    chk(g == e && !(reg_wr_en && reg_rd_en), "bus_op",
                        128'(g), 128'(e));
                end
            end
            if (tx_fifo_wr_en) begin
                logv = {logv[119:0], tx_fifo_data};
                logn++;
                if (exp_tx.size() == 0) begin
                    chk(1'b0, "unexpected_tx", 128'(tx_fifo_data), 128'(0));
                end else begin
                    eb = exp_tx.pop_front();
                    chk(tx_fifo_data == eb, "tx_byte",
                        128'(tx_fifo_data), 128'(eb));
                end
            end
        end
    end

    function automatic bit is_hex(input logic [7:0] c);
        return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") ||
               (c >= "a" && c <= "f");
    endfunction

    function automatic logic [3:0] hexval(input logic [7:0] c);
        if (c >= "0" && c <= "9") return 4'(c - 8'h30);
        if (c >= "A" && c <= "F") return 4'(c - 8'h41 + 8'd10);
        return 4'(c - 8'h61 + 8'd10);
    endfunction

    function automatic logic [7:0] hexc(input logic [3:0] n);
        string hx;
        hx = "0123456789ABCDEF";
        return hx[n];
    endfunction

    // Line model: strip leading CR/LF, classify the letter, count the digits.
    task automatic model_line();
        int i;
        int n;
        int op;
        int cnt;
        bit err;
        logic [63:0] v;
        logic [15:0] d;
        logic [7:0]  c;
        i = 0;
        n = cur.size();
        err = 1'b0;
        cnt = 0;
        v = '0;
        while (i < n && (cur[i] == 8'h0D || cur[i] == 8'h0A)) i++;
        c = cur[i];
        i++;
        if (c == "W" || c == "w") op = 1;
        else if (c == "R" || c == "r") op = 2;
        else begin
            op = 0;
            err = 1'b1;
        end
        while (i < n && cur[i] != 8'h0D) begin
            if (is_hex(cur[i])) begin
                cnt++;
                v = {v[59:0], hexval(cur[i])};
            end else begin
                err = 1'b1;
            end
            i++;
        end
        if (!err && op == 1 && cnt == 6) begin
            exp_bus.push_back({1'b1, v[23:16], v[15:0]});
            exp_tx.push_back("K");
        end else if (!err && op == 2 && cnt == 2) begin
            exp_bus.push_back({1'b0, v[7:0], 16'h0000});
            d = rdmem[v[7:0]];
            for (int k = 3; k >= 0; k--) exp_tx.push_back(hexc(d[4*k +: 4]));
        end else begin
            exp_tx.push_back("E");
        end
        exp_tx.push_back(8'h0D);
        exp_tx.push_back(8'h0A);
    endtask

    task automatic put_str(input string s);
        cur.delete();
        for (int i = 0; i < s.len(); i++) cur.push_back(s[i]);
    endtask

    task automatic send_cur(input bit use_model);
        foreach (cur[i]) begin
            rx_mem[wr_ptr] = cur[i];
            wr_ptr = wr_ptr + 1;
        end
        if (use_model) model_line();
    endtask

    task automatic gen_line();
        int lead;
        int kind;
        int op;
        int nd;
        int badpos;
        int h;
        string hb;
        string bb;
        hb = "XZq1G:";
        bb = "GgXz -\n:";
        cur.delete();
        lead = $urandom_range(0, 3);
        if (lead == 1) cur.push_back(8'h0A);
        if (lead == 2) begin
            cur.push_back(8'h0D);
            cur.push_back(8'h0A);
        end
        if (lead == 3) cur.push_back(8'h0D);
        kind = $urandom_range(0, 9);
        op = (kind < 4) ? 1 : (kind < 7) ? 2 : (kind == 7) ? 0 : $urandom_range(1, 2);
        if (op == 1) cur.push_back($urandom_range(0, 1) ? 8'h57 : 8'h77);
        else if (op == 2) cur.push_back($urandom_range(0, 1) ? 8'h52 : 8'h72);
        else cur.push_back(hb[$urandom_range(0, hb.len() - 1)]);
        nd = (op == 1) ? 6 : (op == 2) ? 2 : $urandom_range(0, 6);
        if (kind == 8) begin
            case ($urandom_range(0, 3))
                0: nd = nd - 1;
                1: nd = nd + 1;
                2: nd = nd + 3;
                default: nd = nd - 2;
            endcase
        end
        badpos = (kind == 9) ? $urandom_range(0, nd - 1) : -1;
        for (int j = 0; j < nd; j++) begin
            if (j == badpos) begin
                cur.push_back(bb[$urandom_range(0, bb.len() - 1)]);
            end else begin
                h = $urandom_range(0, 15);
                if (h < 10) cur.push_back(8'(8'h30 + h));
                else cur.push_back(8'(($urandom_range(0, 1) ? 8'h41 : 8'h61) + h - 10));
            end
        end
        cur.push_back(8'h0D);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (t < 20000 && !(rd_ptr == wr_ptr && exp_tx.size() == 0 &&
                               exp_bus.size() == 0)) begin
            @(posedge clk);
            #1;
            if (full_rand) tx_fifo_full = ($urandom_range(0, 2) == 0);
            t++;
        end
        chk(t < 20000, "idle_timeout", 128'(t), 128'(20000));
        tx_fifo_full = 1'b0;
        repeat (12) @(posedge clk);
        #1;
    endtask

    function automatic logic [35:0] outs();
        return {reg_addr, reg_wr_en, reg_wr_data, reg_rd_en,
                tx_fifo_data, tx_fifo_wr_en, rx_fifo_rd_en};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int w0;
        int r0;
        int nrx;
        int ntx;
        bit found;
        for (int i = 0; i < 256; i++) rdmem[i] = 16'($urandom);
        rdmem[8'h1A] = 16'h00C3;
        rdmem[8'h05] = 16'h5A0F;

        repeat (3) @(negedge clk);
        chk(outs() == '0, "reset_outputs", 128'(outs()), 128'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        w0 = wr_cnt;
        r0 = rd_cnt;
        logv = '0;
        logn = 0;
        put_str("W1ABEEF\r");
        send_cur(1'b1);
        wait_idle();
        chk(wr_cnt == w0 + 1 && rd_cnt == r0, "w1a_count",
            128'(wr_cnt - w0), 128'(1));
        chk(last_addr == 8'h1A && last_wdata == 16'hBEEF, "w1a_bus",
            128'({last_addr, last_wdata}), 128'(24'h1ABEEF));
        chk(logn == 3 && logv[23:0] == 24'h4B0D0A, "w1a_resp",
            128'(logv[23:0]), 128'(24'h4B0D0A));

        w0 = wr_cnt;
        r0 = rd_cnt;
        logv = '0;
        logn = 0;
        put_str("R1A\r");
        send_cur(1'b1);
        wait_idle();
        chk(rd_cnt == r0 + 1 && wr_cnt == w0 && last_addr == 8'h1A, "r1a_bus",
            128'(last_addr), 128'(8'h1A));
        chk(logn == 6 && logv[47:0] == 48'h3030_4333_0D0A, "r1a_resp",
            128'(logv[47:0]), 128'(48'h3030_4333_0D0A));

        logv = '0;
        logn = 0;
        put_str("\n\rw0fab12\r");
        send_cur(1'b1);
        wait_idle();
        chk(last_addr == 8'h0F && last_wdata == 16'hAB12, "w0f_bus",
            128'({last_addr, last_wdata}), 128'(24'h0FAB12));
        chk(logn == 3 && logv[23:0] == 24'h4B0D0A, "w0f_resp",
            128'(logv[23:0]), 128'(24'h4B0D0A));

        w0 = wr_cnt;
        r0 = rd_cnt;
        logv = '0;
        logn = 0;
        put_str("W1G0000\r");
        send_cur(1'b1);
        put_str("R123\r");
        send_cur(1'b1);
        put_str("X\r");
        send_cur(1'b1);
        wait_idle();
        chk(wr_cnt == w0 && rd_cnt == r0, "err_no_strobe",
            128'(wr_cnt - w0 + rd_cnt - r0), 128'(0));
        chk(logn == 9 && logv[71:0] == 72'h450D0A_450D0A_450D0A, "err_resp",
            128'(logv[71:0]), 128'(72'h450D0A_450D0A_450D0A));

        logv = '0;
        logn = 0;
        put_str("R1A\r");
        send_cur(1'b1);
        put_str("R05\r");
        send_cur(1'b1);
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (reg_rd_en) found = 1'b1;
        end
        chk(found, "rd_strobe_seen", 128'(found), 128'(1));
        @(posedge clk);
        #1 tx_fifo_full = 1'b1;
        nrx = 0;
        ntx = 0;
        repeat (100) begin
            @(negedge clk);
            if (rx_fifo_rd_en) nrx++;
            if (tx_fifo_wr_en) ntx++;
        end
        chk(nrx == 0 && ntx == 0, "stall_while_full",
            128'({nrx, ntx}), 128'(0));
        @(posedge clk);
        #1 tx_fifo_full = 1'b0;
        wait_idle();
        chk(logn == 12 && logv[95:0] == 96'h3030_4333_0D0A_3541_3046_0D0A,
            "full_resp", 128'(logv[95:0]),
            128'(96'h3030_4333_0D0A_3541_3046_0D0A));

        w0 = wr_cnt;
        put_str("W12");
        send_cur(1'b0);
        wait_idle();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk(outs() == '0, "midreset_outputs", 128'(outs()), 128'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        r0 = rd_cnt;
        logv = '0;
        logn = 0;
        put_str("R05\r");
        send_cur(1'b1);
        wait_idle();
        chk(wr_cnt == w0, "no_write_after_reset", 128'(wr_cnt - w0), 128'(0));
        chk(rd_cnt == r0 + 1 && last_addr == 8'h05, "r05_bus",
            128'(last_addr), 128'(8'h05));
        chk(logn == 6 && logv[47:0] == 48'h3541_3046_0D0A, "r05_resp",
            128'(logv[47:0]), 128'(48'h3541_3046_0D0A));

        full_rand = 1'b1;
        for (int b = 0; b < 10; b++) begin
            for (int l = 0; l < 8; l++) begin
                gen_line();
                send_cur(1'b1);
            end
            wait_idle();
        end
        full_rand = 1'b0;
        chk(exp_bus.size() == 0 && exp_tx.size() == 0, "leftover_expect",
            128'(exp_bus.size() + exp_tx.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
